// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ---- apb_mem_pkg : FSM state type, wait-state limit, lane helper ---- rev 1.0
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int WAIT_CYC_MAX = 15;
  localparam int CNT_W        = $clog2(WAIT_CYC_MAX + 1);

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ---- apb_mem_array : DEPTH x DATA_W storage, per-lane write, registered read ---- rev 1.0
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  logic                        rd_clr,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [DATA_W-1:0]           rd_data,
  input  logic [lanes_of(DATA_W)-1:0] wr_be,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [DATA_W-1:0]           wr_data
);

  localparam int LANES = lanes_of(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // The read register doubles as the bus PRDATA register, so it owns the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_idx];
  end

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ---- apb_mem_slave : APB word-memory slave with wait states and PSLVERR ---- rev 1.0
// Optional byte strobes: define APB_MEM_PSTRB_EN to add the PSTRB port.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0
) (
  input  logic                   PCLK,
  input  logic                   PRST_N,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDR_W-1:0]      PADDR,
  input  logic [DATA_W-1:0]      PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0]    PSTRB,
`endif
  output logic [DATA_W-1:0]      PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR
);

  localparam int LANES = lanes_of(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [LANES-1:0]   strb_q;

  logic [LANES-1:0]   strb_in;
  logic [ADDR_W-1:0]  cur_addr;
  logic               cur_write;
  logic               cur_in_range;
  logic               setup;
  logic               enter_ready;
  logic               complete;
  logic               rd_en;
  logic               rd_clr;
  logic [LANES-1:0]   wr_be;

`ifdef APB_MEM_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  // In IDLE the live bus is used so a zero-wait read can fetch on the setup edge.
  always_comb begin
    setup        = PSEL && !PENABLE;
    cur_addr     = (state == IDLE) ? PADDR  : addr_q;
    cur_write    = (state == IDLE) ? PWRITE : write_q;
    cur_in_range = 32'(cur_addr) < 32'(DEPTH);
    enter_ready  = ((state == IDLE) && setup && (WAIT_CYC == 0)) ||
                   ((state == WAIT) && PSEL && (cnt == CNT_W'(1)));
    complete     = (state == READY) && PSEL && PENABLE && PREADY;
    rd_en        = enter_ready && !cur_write && cur_in_range;
    rd_clr       = (state != IDLE) && (!PSEL || complete);
    wr_be        = (complete && write_q && cur_in_range) ? strb_q : '0;
  end

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= strb_in;
            if (WAIT_CYC == 0) begin
              state   <= READY;
              PREADY  <= 1'b1;
              PSLVERR <= !cur_in_range;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYC);
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state   <= READY;
            cnt     <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= !cur_in_range;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        READY: begin
          if (!PSEL || complete) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (PCLK),
    .rst_n   (PRST_N),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_idx  (cur_addr[IDX_W-1:0]),
    .rd_data (PRDATA),
    .wr_be   (wr_be),
    .wr_idx  (addr_q[IDX_W-1:0]),
    .wr_data (wdata_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ---- tb_apb_mem_slave : scoreboard bench over three slave configurations ---- rev 1.0
module tb_apb_mem_slave;

  // Instance 0: no wait, 16 words. Instance 1: 3 waits, 32 words. Instance 2: 2 waits, 16 words.
  localparam int WC [3] = '{0, 3, 2};
  localparam int DP [3] = '{16, 32, 16};

  logic        pclk;
  logic        prst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [3][32];
  int          n_tests = 0;
  int          n_fail  = 0;

  apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYC(0)) u_dut0 (
    .PCLK(pclk), .PRST_N(prst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(32), .WAIT_CYC(3)) u_dut1 (
    .PCLK(pclk), .PRST_N(prst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYC(2)) u_dut2 (
    .PCLK(pclk), .PRST_N(prst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full APB transfer; expectation is queued at setup and retired when PREADY shows.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    exp_t       e;
    exp_t       got_e;
    int         lat;
    logic [4:0] ai;
    bit         in_rng;
    ai      = a[4:0];
    in_rng  = int'(a) < DP[d];
    e.err   = !in_rng;
    e.rdata = (!wr && in_rng) ? model[d][ai] : 32'h0;
    e.lat   = WC[d];
    sb.push_back(e);
    @(negedge pclk);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0;
    while (!pready[d] && lat < 40) begin
      @(negedge pclk);
      lat++;
    end
    got_e = sb.pop_front();
    if (!pready[d]) check("pready_timeout", 64'(pready[d]), 64'(1));
    check("latency", 64'(lat), 64'(got_e.lat));
    check("pslverr", 64'(pslverr[d]), 64'(got_e.err));
    check("prdata", 64'(prdata[d]), 64'(got_e.rdata));
    if (wr && in_rng) begin
      for (int i = 0; i < 4; i++) begin
`ifdef APB_MEM_PSTRB_EN
        if (st[i]) model[d][ai][8*i +: 8] = wd[8*i +: 8];
`else
        model[d][ai][8*i +: 8] = wd[8*i +: 8];
`endif
      end
    end
  endtask

  task automatic idle_check(input int d);
    @(negedge pclk);
    check("pready_clear", 64'(pready[d]), 64'(0));
    check("prdata_clear", 64'(prdata[d]), 64'(0));
    check("pslverr_clear", 64'(pslverr[d]), 64'(0));
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prst_n  = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = 4'hF;
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      check("rst_pready", 64'(pready[d]), 64'(0));
      check("rst_pslverr", 64'(pslverr[d]), 64'(0));
      check("rst_prdata", 64'(prdata[d]), 64'(0));
    end
    prst_n = 1'b1;

    // Zero-wait write then back-to-back read
    xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 8'h05, 32'h0, 4'hF);
    idle_check(0);

    // Three wait states
    xfer(1, 1'b1, 8'h10, 32'h12345678, 4'hF);
    xfer(1, 1'b1, 8'h05, 32'h5A5A0005, 4'hF);
    xfer(1, 1'b0, 8'h05, 32'h0, 4'hF);
    xfer(1, 1'b0, 8'h10, 32'h0, 4'hF);
    idle_check(1);

    // Random back-to-back write/read pairs
    for (int k = 0; k < 6; k++) begin
      int          d;
      logic [7:0]  a;
      logic [31:0] wd;
      d  = k % 2;
      a  = 8'($urandom_range(0, 15));
      if (d == 1 && a == 8'h10) a = 8'h11;
      wd = $urandom;
      xfer(d, 1'b1, a, wd, 4'hF);
      xfer(d, 1'b0, a, 32'h0, 4'hF);
    end
    idle_check(0);

    // Out-of-range accesses must not alias onto low words
    xfer(0, 1'b1, 8'h00, 32'h0000C0DE, 4'hF);
    xfer(0, 1'b1, 8'h20, 32'h000000A5, 4'hF);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF);
    xfer(0, 1'b0, 8'h20, 32'h0, 4'hF);
    idle_check(0);

`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1'b1, 8'h03, 32'h11223344, 4'hF);
    xfer(0, 1'b1, 8'h03, 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b0, 8'h03, 32'h0, 4'hF);
    check("strobe_word", 64'(model[0][3]), 64'h11BB33DD);
    xfer(0, 1'b1, 8'h03, 32'hFFFFFFFF, 4'b0000);
    xfer(0, 1'b0, 8'h03, 32'h0, 4'hF);
    idle_check(0);
`endif

    // Abort a two-wait write after one access cycle
    xfer(2, 1'b1, 8'h03, 32'h33333333, 4'hF);
    idle_check(2);
    @(negedge pclk);
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h03;
    pwdata  = 32'h0BADF00D;
    @(negedge pclk);
    penable = 1'b1;
    check("abort_access", 64'(pready[2]), 64'(0));
    @(negedge pclk);
    psel    = '0;
    penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      check("abort_pready", 64'(pready[2]), 64'(0));
    end
    xfer(2, 1'b0, 8'h03, 32'h0, 4'hF);
    idle_check(2);

    // Reset while a zero-wait read is presenting data
    @(negedge pclk);
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    @(negedge pclk);
    penable = 1'b1;
    check("pre_rst_pready", 64'(pready[0]), 64'(1));
    check("pre_rst_prdata", 64'(prdata[0]), 64'(model[0][0]));
    #2 prst_n = 1'b0;
    #1;
    check("async_rst_pready", 64'(pready[0]), 64'(0));
    check("async_rst_prdata", 64'(prdata[0]), 64'(0));
    check("async_rst_pslverr", 64'(pslverr[0]), 64'(0));
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    prst_n = 1'b1;

    // Reset in the wait phase of a write drops the write
    @(negedge pclk);
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h10;
    pwdata  = 32'hCAFEF00D;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #2 prst_n = 1'b0;
    #1;
    check("wait_rst_pready", 64'(pready[1]), 64'(0));
    check("wait_rst_prdata", 64'(prdata[1]), 64'(0));
    @(negedge pclk);
    prst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      check("post_rst_pready", 64'(pready[1]), 64'(0));
    end
    psel    = '0;
    penable = 1'b0;
    xfer(1, 1'b0, 8'h10, 32'h0, 4'hF);
    check("mem_after_rst", 64'(model[1][16]), 64'h12345678);
    idle_check(1);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
